// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter generator.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EXC  = 3'd0,
    ERET = 3'd1,
    JMP  = 3'd2,
    BR   = 3'd3,
    SEQ  = 3'd4,
    HOLD = 3'd5
  } next_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control-side request lines and fetch-port outputs of pc_gen; master is the PC generator itself.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             pcwr;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic             exc_req;
    logic             eret;
    logic             fetch_ready;
    logic [WIDTH-1:0] pc;
    logic             fetch_valid;
    logic [WIDTH-1:0] epc;
    logic             in_exc;
    logic             misalign;

    modport master (
        input  pcwr, br_taken, br_target, jmp, jmp_target, exc_req, eret, fetch_ready,
        output pc, fetch_valid, epc, in_exc, misalign
    );

    modport slave (
        output pcwr, br_taken, br_target, jmp, jmp_target, exc_req, eret, fetch_ready,
        input  pc, fetch_valid, epc, in_exc, misalign
    );
endinterface

// File: rtl/pc_next_mux.sv
// Priority select of the next PC (exception > eret > jump > branch > sequential > hold)
// plus the alignment check on the chosen redirect target.
module pc_next_mux
  import pc_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DEF_EXC_VEC),
    parameter int               STEP    = 4
) (
    input  state_e           state,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic             fetch_ready,
    output next_sel_e        sel,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] target,
    output logic             misalign
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic bad_target;

    assign target     = jmp ? jmp_target : br_target;
    assign bad_target = |(target & ALIGN_MASK);

    // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
    always_comb begin
        sel      = HOLD;
        next_pc  = pc;
        misalign = 1'b0;
        if (exc_req && state == RUN) begin
            sel     = EXC;
            next_pc = EXC_VEC;
        end else if (eret && state == HANDLER) begin
            sel     = ERET;
            next_pc = epc;
        end else if (jmp || br_taken) begin
            sel      = jmp ? JMP : BR;
            misalign = bad_target;
            // A bad target traps from RUN; inside the handler it is simply dropped.
            if (!bad_target)       next_pc = target;
            else if (state == RUN) next_pc = EXC_VEC;
        end else if (fetch_ready) begin
            sel     = SEQ;
            next_pc = pc + WIDTH'(STEP);
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: BOOT/RUN/HANDLER state, PC and EPC registers, misalign pulse.
module pc_gen
  import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               STEP      = 4
) (
    input logic       clk,
    input logic       rst,
    pc_gen_if.master  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             misalign_q, misalign_d;

    next_sel_e        sel;
    logic [WIDTH-1:0] nxt_pc;
    logic [WIDTH-1:0] target;
    logic             bad;

    pc_next_mux #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC),
        .STEP    (STEP)
    ) u_mux (
        .state       (state_q),
        .pc          (pc_q),
        .epc         (epc_q),
        .br_taken    (bus.br_taken),
        .br_target   (bus.br_target),
        .jmp         (bus.jmp),
        .jmp_target  (bus.jmp_target),
        .exc_req     (bus.exc_req),
        .eret        (bus.eret),
        .fetch_ready (bus.fetch_ready),
        .sel         (sel),
        .next_pc     (nxt_pc),
        .target      (target),
        .misalign    (bad)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (bus.pcwr) begin
            pc_d = nxt_pc;
            case (sel)
                EXC: begin
                    epc_d   = pc_q;
                    state_d = HANDLER;
                end
                ERET: state_d = RUN;
                JMP, BR: begin
                    misalign_d = bad;
                    if (bad && state_q == RUN) begin
                        epc_d   = target;
                        state_d = HANDLER;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.epc         = epc_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_valid = (state_q != BOOT);
    assign bus.in_exc      = (state_q == HANDLER);
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, random run against a reference model,
// and an 8-bit instance for address wrap and asynchronous reset.
module tb_pc_gen;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst8 = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(32)) b0 ();
    pc_gen_if #(.WIDTH(8))  b1 ();

    pc_gen #(.WIDTH(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pc_gen #(.WIDTH(8), .RESET_VEC(8'hF8), .STEP(4)) u1 (.clk(clk), .rst(rst8), .bus(b1));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        pcwr, br, jmp, exc, eret, rdy;
        logic [31:0] bt, jt;
        logic [31:0] e_pc, e_epc;
        logic        e_valid, e_inexc, e_mis;
    } vec_t;

    function automatic vec_t mk(input logic pcwr, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt, input logic exc,
                                input logic eret, input logic rdy, input logic [31:0] e_pc,
                                input logic [31:0] e_epc, input logic e_inexc, input logic e_mis);
        vec_t v;
        v.pcwr = pcwr; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.exc = exc; v.eret = eret; v.rdy = rdy;
        v.e_pc = e_pc; v.e_epc = e_epc; v.e_valid = 1'b1; v.e_inexc = e_inexc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic drive0(input logic pcwr, input logic br, input logic [31:0] bt, input logic jmp,
                          input logic [31:0] jt, input logic exc, input logic eret, input logic rdy);
        b0.pcwr = pcwr; b0.br_taken = br; b0.br_target = bt; b0.jmp = jmp; b0.jmp_target = jt;
        b0.exc_req = exc; b0.eret = eret; b0.fetch_ready = rdy;
    endtask

    task automatic check0(input string tag, input logic [31:0] e_pc, input logic e_valid,
                          input logic [31:0] e_epc, input logic e_inexc, input logic e_mis);
        check({tag, ".pc"},          b0.pc,                 e_pc);
        check({tag, ".fetch_valid"}, {31'd0, b0.fetch_valid}, {31'd0, e_valid});
        check({tag, ".epc"},         b0.epc,                e_epc);
        check({tag, ".in_exc"},      {31'd0, b0.in_exc},    {31'd0, e_inexc});
        check({tag, ".misalign"},    {31'd0, b0.misalign},  {31'd0, e_mis});
    endtask

    vec_t vecs[20];

    // Reference model state for the random phase
    bit          m_booted, m_handler, m_mis;
    logic [31:0] m_pc, m_epc;

    initial begin
        drive0(0, 0, 0, 0, 0, 0, 0, 0);
        b1.pcwr = 1'b0; b1.br_taken = 1'b0; b1.br_target = '0; b1.jmp = 1'b0;
        b1.jmp_target = '0; b1.exc_req = 1'b0; b1.eret = 1'b0; b1.fetch_ready = 1'b0;

        //            pcwr br bt            jmp jt            exc eret rdy  pc            epc           ie m
        vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h3000, 32'h0,    0, 0);
        vecs[1]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h3004, 32'h0,    0, 0);
        vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h3008, 32'h0,    0, 0);
        vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h3008, 32'h0,    0, 0);
        vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h3008, 32'h0,    0, 0);
        vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h3008, 32'h0,    0, 0);
        vecs[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h300C, 32'h0,    0, 0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 32'h3100,     0, 0, 1, 32'h300C, 32'h0,    0, 0);
        vecs[8]  = mk(1, 1, 32'h3200,     1, 32'h3100,     0, 0, 1, 32'h3100, 32'h0,    0, 0);
        vecs[9]  = mk(1, 1, 32'h3202,     0, 32'h0,        0, 0, 1, 32'h4180, 32'h3202, 1, 1);
        vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h4180, 32'h3202, 1, 0);
        vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h4184, 32'h3202, 1, 0);
        vecs[12] = mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h3202, 32'h3202, 0, 0);
        vecs[13] = mk(1, 0, 32'h0,        1, 32'h300C,     0, 0, 1, 32'h300C, 32'h3202, 0, 0);
        vecs[14] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h3010, 32'h3202, 0, 0);
        vecs[15] = mk(1, 0, 32'h0,        1, 32'h3100,     1, 0, 1, 32'h4180, 32'h3010, 1, 0);
        vecs[16] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h4184, 32'h3010, 1, 0);
        vecs[17] = mk(1, 0, 32'h0,        1, 32'h3001,     0, 0, 1, 32'h4184, 32'h3010, 1, 1);
        vecs[18] = mk(1, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h3010, 32'h3010, 0, 0);
        vecs[19] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h3014, 32'h3010, 0, 0);

        // Reset values, then one BOOT cycle with fetch_valid low after release
        repeat (2) @(posedge clk);
        #1;
        check0("reset", 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        check0("boot", 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive0(vecs[i].pcwr, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt,
                   vecs[i].exc, vecs[i].eret, vecs[i].rdy);
            @(posedge clk);
            #1;
            check0($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_epc,
                   vecs[i].e_inexc, vecs[i].e_mis);
        end

        // Random run against the reference model
        drive0(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_booted = 0; m_handler = 0; m_mis = 0; m_pc = 32'h3000; m_epc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] bt, jt, t;
            logic pcwr, br, jmp, exc, eret, rdy;
            bt = 32'h3000 + ($urandom_range(0, 1023) << 2);
            jt = 32'h3000 + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 3) == 0) bt = bt + $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) jt = jt + $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) jt = 32'hFFFF_FFFC;
            pcwr = ($urandom_range(0, 7) != 0);
            br   = ($urandom_range(0, 5) == 0);
            jmp  = ($urandom_range(0, 5) == 0);
            exc  = ($urandom_range(0, 7) == 0);
            eret = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 1) == 0);
            drive0(pcwr, br, bt, jmp, jt, exc, eret, rdy);
            @(posedge clk);
            #1;
            m_mis = 0;
            if (!m_booted) begin
                m_booted = 1;
            end else if (pcwr) begin
                if (exc && !m_handler) begin
                    m_epc = m_pc; m_pc = 32'h4180; m_handler = 1;
                end else if (eret && m_handler) begin
                    m_pc = m_epc; m_handler = 0;
                end else if (jmp || br) begin
                    t = jmp ? jt : bt;
                    if (t % 4 != 0) begin
                        m_mis = 1;
                        if (!m_handler) begin
                            m_epc = t; m_pc = 32'h4180; m_handler = 1;
                        end
                    end else begin
                        m_pc = t;
                    end
                end else if (rdy) begin
                    m_pc = m_pc + 32'd4;
                end
            end
            check0($sformatf("rnd%0d", n), m_pc, m_booted, m_epc, m_handler, m_mis);
        end

        // 8-bit instance: wrap past the top address, then async reset mid-cycle
        b1.pcwr = 1'b1; b1.fetch_ready = 1'b1;
        rst8 = 1'b0;
        @(posedge clk); #1;
        check("w8.pc0", {24'd0, b1.pc}, 32'hF8);
        check("w8.valid0", {31'd0, b1.fetch_valid}, 32'd1);
        @(posedge clk); #1;
        check("w8.pc1", {24'd0, b1.pc}, 32'hFC);
        @(posedge clk); #1;
        check("w8.pc2", {24'd0, b1.pc}, 32'h00);
        @(posedge clk); #1;
        check("w8.pc3", {24'd0, b1.pc}, 32'h04);
        rst8 = 1'b1;
        #2;
        check("w8.rst_pc", {24'd0, b1.pc}, 32'hF8);
        check("w8.rst_valid", {31'd0, b1.fetch_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
